gpio_cmd_decoder: RTL and testbench

GPIO_CMD_DECODER -- requirements
Module: gpio_cmd_decoder

---
 rtl/gpio_cmd_decoder_pkg.sv | 21 ++
 rtl/gpio_cmd_decoder_edge_sync.sv | 40 ++++
 rtl/gpio_cmd_decoder.sv | 123 ++++++++++++
 tb/tb_gpio_cmd_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_cmd_decoder_pkg.sv
// gpio_cmd_decoder_pkg: command codes, gpi0 bit positions and FSM encoding shared by the GPIO command decoder.
package gpio_cmd_decoder_pkg;

    localparam logic [6:0] CMD_WR_PIXEL = 7'h01;
    localparam logic [6:0] CMD_RD_PIXEL = 7'h02;
    localparam logic [6:0] CMD_SET_ADDR = 7'h03;
    localparam logic [6:0] CMD_START    = 7'h04;
    localparam logic [6:0] CMD_STATUS   = 7'h05;

    localparam int GPI_ACK  = 31;
    localparam int GPI_ERR  = 30;
    localparam int GPI_BUSY = 29;
    localparam int GPI_DONE = 28;

    typedef enum logic [1:0] {IDLE, EXEC, RD_WAIT, RESP} state_e;

    function automatic logic cmd_legal(input logic [6:0] cmd);
        return cmd >= CMD_WR_PIXEL && cmd <= CMD_STATUS;
    endfunction

endpackage

// File: rtl/gpio_cmd_decoder_edge_sync.sv
// gpio_edge_sync: registers the GPO word (2-flop synchroniser when GPIO_CDC_SYNC_EN is defined)
// and flags the rising edge of its top (strobe) bit.
module gpio_edge_sync #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] word_i,
    output logic [W-1:0] word_o,
    output logic         edge_o
);

    logic [W-1:0] sync_q;
    logic         prev_q;
    logic [W-1:0] rst_word;

    // During reset every strobe stage loads the live bit, so a strobe held high across release is no edge.
    assign rst_word = {word_i[W-1], {(W-1){1'b0}}};

`ifdef GPIO_CDC_SYNC_EN
    logic [W-1:0] meta_q;

    always_ff @(posedge clock) begin
        meta_q <= reset ? rst_word : word_i;
        sync_q <= reset ? rst_word : meta_q;
    end
`else
    always_ff @(posedge clock) begin
        sync_q <= reset ? rst_word : word_i;
    end
`endif

    always_ff @(posedge clock) begin
        prev_q <= reset ? word_i[W-1] : sync_q[W-1];
    end

    assign word_o = sync_q;
    assign edge_o = sync_q[W-1] & ~prev_q;

endmodule

// File: rtl/gpio_cmd_decoder.sv
// gpio_cmd_decoder: decodes strobed micro commands on gpo0 into pixel RAM / convolution control.
// Define GPIO_CDC_SYNC_EN to put a 2-flop synchroniser in front of strobe edge detection.
module gpio_cmd_decoder
    import gpio_cmd_decoder_pkg::*;
#(
    parameter int NB_GPIOS  = 32,
    parameter int NB_C0M    = 7,
    parameter int NB_DATA   = 24,
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 2**16,
    parameter int NB_ADDR   = $clog2(RAM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NB_GPIOS-1:0]  gpo0,
    output logic [NB_GPIOS-1:0]  gpi0,
    output logic                 o_ram_we,
    output logic [NB_ADDR-1:0]   o_ram_addr,
    output logic [RAM_WIDTH-1:0] o_ram_wdata,
    output logic                 o_ram_re,
    input  logic [RAM_WIDTH-1:0] i_ram_rdata,
    output logic                 o_conv_start,
    input  logic                 i_conv_busy,
    input  logic                 i_conv_done
);

    state_e               state_q;
    logic [NB_C0M-1:0]    cmd_q;
    logic [NB_DATA-1:0]   data_q;
    logic [NB_DATA-1:0]   resp_q;
    logic [NB_ADDR-1:0]   addr_q;
    logic [NB_ADDR-1:0]   addr_d;
    logic [NB_ADDR-1:0]   ram_addr_q;
    logic [RAM_WIDTH-1:0] wdata_q;
    logic                 ack_q, err_q, busy_q, done_q;
    logic                 we_q, re_q, start_q;
    logic [NB_GPIOS-1:0]  word;
    logic                 strobe_edge;
    logic                 start_ok;
    logic                 unused;

    gpio_edge_sync #(.W(NB_GPIOS)) u_edge_sync (
        .clock  (clock),
        .reset  (reset),
        .word_i (gpo0),
        .word_o (word),
        .edge_o (strobe_edge)
    );

    assign addr_d   = (addr_q == NB_ADDR'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
    assign start_ok = state_q == EXEC && cmd_q == CMD_START && !i_conv_busy;
    assign unused   = ^{word[NB_GPIOS-1], data_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            addr_q     <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= i_conv_busy;
            // A done pulse in the same cycle as an accepted START must leave the sticky set.
            done_q  <= i_conv_done | (done_q & ~start_ok);
            case (state_q)
                IDLE: if (strobe_edge) begin
                    cmd_q   <= word[NB_DATA+NB_C0M-1:NB_DATA];
                    data_q  <= word[NB_DATA-1:0];
                    state_q <= EXEC;
                end
                EXEC: begin
                    state_q <= (cmd_q == CMD_RD_PIXEL) ? RD_WAIT : RESP;
                    err_q   <= !cmd_legal(cmd_q) || (cmd_q == CMD_START && i_conv_busy);
                    start_q <= start_ok;
                    if (cmd_q == CMD_WR_PIXEL || cmd_q == CMD_RD_PIXEL) begin
                        we_q       <= cmd_q == CMD_WR_PIXEL;
                        re_q       <= cmd_q == CMD_RD_PIXEL;
                        wdata_q    <= data_q[RAM_WIDTH-1:0];
                        ram_addr_q <= addr_q;
                        addr_q     <= addr_d;
                    end
                    if (cmd_q == CMD_SET_ADDR)
                        addr_q <= data_q[NB_ADDR-1:0];
                end
                RD_WAIT: state_q <= RESP;
                RESP: begin
                    ack_q   <= ~ack_q;
                    resp_q  <= (cmd_q == CMD_RD_PIXEL) ? NB_DATA'(i_ram_rdata) : NB_DATA'(addr_q);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        gpi0                = '0;
        gpi0[GPI_ACK]       = ack_q;
        gpi0[GPI_ERR]       = err_q;
        gpi0[GPI_BUSY]      = busy_q;
        gpi0[GPI_DONE]      = done_q;
        gpi0[NB_DATA-1:0]   = resp_q;
    end

    assign o_ram_we     = we_q;
    assign o_ram_re     = re_q;
    assign o_ram_addr   = ram_addr_q;
    assign o_ram_wdata  = wdata_q;
    assign o_conv_start = start_q;

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// tb_gpio_cmd_decoder: directed commands with queued expected responses and RAM writes, checked by a monitor.
module tb_gpio_cmd_decoder;

    localparam logic [6:0] WR = 7'h01, RD = 7'h02, SA = 7'h03, ST = 7'h04, STS = 7'h05;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] gpo0 = '0;
    logic [31:0] gpi0;
    logic        o_ram_we, o_ram_re, o_conv_start;
    logic [15:0] o_ram_addr;
    logic [7:0]  o_ram_wdata;
    logic [7:0]  i_ram_rdata;
    logic        i_conv_busy = 1'b0;
    logic        i_conv_done = 1'b0;

    logic [7:0]  mem [0:65535];
    logic [30:0] exp_q[$];
    logic [23:0] wr_q[$];
    logic        last_ack;
    int          checks = 0;
    int          errors = 0;
    int          starts = 0;

    gpio_cmd_decoder dut (
        .clock        (clock),
        .reset        (reset),
        .gpo0         (gpo0),
        .gpi0         (gpi0),
        .o_ram_we     (o_ram_we),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .o_ram_re     (o_ram_re),
        .i_ram_rdata  (i_ram_rdata),
        .o_conv_start (o_conv_start),
        .i_conv_busy  (i_conv_busy),
        .i_conv_done  (i_conv_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
        if (o_ram_re) i_ram_rdata <= mem[o_ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [30:0] rsp(input bit err, input bit busy, input bit done, input logic [23:0] d);
        return {err, busy, done, 4'b0, d};
    endfunction

    // Monitor: pops an expected response on every ack toggle and an expected write on every we pulse.
    initial begin
        logic [30:0] e;
        logic [23:0] w;
        last_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) last_ack = 1'b0;
            else begin
                if (gpi0[31] != last_ack) begin
                    last_ack = gpi0[31];
                    if (exp_q.size() == 0) chk("resp_unexpected", gpi0, 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("resp", {1'b0, gpi0[30:0]}, {1'b0, e});
                    end
                end
                if (o_ram_we) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", {8'h0, o_ram_addr, o_ram_wdata}, 32'hFFFF_FFFF);
                    else begin
                        w = wr_q.pop_front();
                        chk("ram_wr", {8'h0, o_ram_addr, o_ram_wdata}, {8'h0, w});
                    end
                end
                if (o_conv_start) starts++;
            end
        end
    end

    // Issue one command; lat counts negedges from strobe drive to ack (1 register stage + 3, RD +1).
    task automatic issue(input logic [6:0] c, input logic [23:0] d, input logic [30:0] e,
                         input int lat, input bit done_pulse);
        logic a0;
        int   n;
        exp_q.push_back(e);
        @(negedge clock);
        a0   = gpi0[31];
        gpo0 = {1'b1, c, d};
        n    = 0;
        while (gpi0[31] == a0 && n < 20) begin
            @(negedge clock);
            n++;
            i_conv_done = done_pulse && n == 2;
        end
        chk("ack_latency", 32'(n), 32'(lat));
        gpo0[31] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        gpo0 = {1'b1, WR, 24'h000099};
        repeat (3) @(negedge clock);
        chk("reset_outs", {gpi0[31:8], o_ram_we, o_ram_re, o_conv_start, 5'b0},
            {24'h0, 8'h0});
        chk("reset_addr", {o_ram_addr, o_ram_wdata, gpi0[7:0]}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("held_strobe_no_ack", {31'h0, gpi0[31]}, 32'h0);
        gpo0[31] = 1'b0;
        repeat (2) @(negedge clock);

        issue(SA, 24'h000010, rsp(0, 0, 0, 24'h10), 4, 0);
        wr_q.push_back({16'h0010, 8'hAB});
        issue(WR, 24'h0000AB, rsp(0, 0, 0, 24'h11), 4, 0);
        issue(SA, 24'h000010, rsp(0, 0, 0, 24'h10), 4, 0);
        issue(RD, 24'h0, rsp(0, 0, 0, 24'hAB), 5, 0);

        issue(SA, 24'h00FFFF, rsp(0, 0, 0, 24'hFFFF), 4, 0);
        wr_q.push_back({16'hFFFF, 8'h11});
        issue(WR, 24'h000011, rsp(0, 0, 0, 24'h0), 4, 0);
        wr_q.push_back({16'h0000, 8'h22});
        issue(WR, 24'h000022, rsp(0, 0, 0, 24'h1), 4, 0);

        issue(SA, 24'h000020, rsp(0, 0, 0, 24'h20), 4, 0);
        wr_q.push_back({16'h0020, 8'h5C});
        issue(WR, 24'h00005C, rsp(0, 0, 0, 24'h21), 4, 0);
        issue(SA, 24'h000020, rsp(0, 0, 0, 24'h20), 4, 0);
        issue(RD, 24'h0, rsp(0, 0, 0, 24'h5C), 5, 0);
        issue(STS, 24'h0, rsp(0, 0, 0, 24'h21), 4, 0);

        i_conv_busy = 1'b1;
        issue(ST, 24'h0, rsp(1, 1, 0, 24'h21), 4, 0);
        issue(STS, 24'h0, rsp(0, 1, 0, 24'h21), 4, 0);
        chk("no_start_when_busy", 32'(starts), 32'd0);
        i_conv_busy = 1'b0;
        repeat (2) @(negedge clock);

        issue(ST, 24'h0, rsp(0, 0, 0, 24'h21), 4, 0);
        @(negedge clock);
        i_conv_done = 1'b1;
        @(negedge clock);
        i_conv_done = 1'b0;
        issue(STS, 24'h0, rsp(0, 0, 1, 24'h21), 4, 0);
        issue(ST, 24'h0, rsp(0, 0, 0, 24'h21), 4, 0);
        issue(ST, 24'h0, rsp(0, 0, 1, 24'h21), 4, 1);
        chk("start_pulses", 32'(starts), 32'd3);

        issue(7'h7F, 24'h0, rsp(1, 0, 1, 24'h21), 4, 0);
        issue(STS, 24'h0, rsp(0, 0, 1, 24'h21), 4, 0);
        chk("no_start_bad_cmd", 32'(starts), 32'd3);

        issue(SA, 24'h000030, rsp(0, 0, 1, 24'h30), 4, 0);
        @(negedge clock);
        gpo0 = {1'b1, WR, 24'h0000EE};
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_gpi0", gpi0, 32'h0);
        chk("abort_ram", {7'h0, o_ram_we, o_ram_re, o_conv_start, o_ram_addr, 6'h0}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_no_ack", {31'h0, gpi0[31]}, 32'h0);
        gpo0[31] = 1'b0;
        repeat (2) @(negedge clock);
        issue(STS, 24'h0, rsp(0, 0, 0, 24'h0), 4, 0);

        repeat (4) @(negedge clock);
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        chk("start_total", 32'(starts), 32'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
